// File: rtl/sw_debounce_ab_pkg.sv
// sw_debounce_ab_pkg: debounce FSM state encoding and default qualification time.
package sw_debounce_ab_pkg;
  localparam int DEB_CYCLES_DEF = 27000;
  localparam logic [1:0] REL    = 2'd0;
  localparam logic [1:0] WAIT_P = 2'd1;
  localparam logic [1:0] PRS    = 2'd2;
  localparam logic [1:0] WAIT_R = 2'd3;
  function automatic logic is_pressed(input logic [1:0] st);
    return st == PRS || st == WAIT_R;
  endfunction
endpackage

// File: rtl/sw_debounce_ch.sv
// sw_debounce_ch: synchronizer, qualification counter and FSM for one push-button.
module sw_debounce_ch
  import sw_debounce_ab_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rls
);
  localparam int W = $clog2(DEB_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DEB_CYCLES - 1);
  logic s1, s2, lvl;
  logic [1:0] st, nst;
  logic [W-1:0] cnt, ncnt;
  assign lvl = ACTIVE_LOW ? ~s2 : s2;
  // counter stops at LAST: the transition fires there, so it never wraps
  always_comb begin
    nst = st;
    ncnt = cnt;
    case (st)
      REL:     if (lvl) begin nst = WAIT_P; ncnt = '0; end
      WAIT_P:  if (!lvl) nst = REL; else if (cnt == LAST) nst = PRS; else ncnt = cnt + 1'b1;
      PRS:     if (!lvl) begin nst = WAIT_R; ncnt = '0; end
      default: if (lvl) nst = PRS; else if (cnt == LAST) nst = REL; else ncnt = cnt + 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= ACTIVE_LOW;
      s2 <= ACTIVE_LOW;
      st <= REL;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rls <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      st <= nst;
      cnt <= ncnt;
      level <= is_pressed(nst);
      press <= st == WAIT_P && nst == PRS;
      rls <= st == WAIT_R && nst == REL;
    end
  end
endmodule

// File: rtl/sw_debounce_ab.sv
// sw_debounce_ab: two independent debounced push-buttons feeding the LED matrix stage.
module sw_debounce_ab
  import sw_debounce_ab_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic swA_raw,
  input  logic swB_raw,
  output logic swA,
  output logic swB,
  output logic swA_press,
  output logic swB_press,
  output logic swA_release,
  output logic swB_release
);
  sw_debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_a (
    .clk(clk), .rst_n(rst_n), .raw(swA_raw), .level(swA), .press(swA_press), .rls(swA_release)
  );
  sw_debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_b (
    .clk(clk), .rst_n(rst_n), .raw(swB_raw), .level(swB), .press(swB_press), .rls(swB_release)
  );
endmodule
